weights_ram_arbiter: RTL

//   Shares one single-port weights RAM (1 op/cycle, 1-cycle read latency) between one

---
 rtl/weights_ram_arbiter_if.sv | 37 +++
 rtl/weights_ram_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/weights_ram_arbiter_if.sv
// Bus bundle between the weights RAM arbiter, its loader/lane requesters and the RAM macro.
// slave = arbiter side, master = everything the arbiter talks to.
interface weights_ram_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 8
);
    localparam int ID_BITS = $clog2(NUM_REQ);

    logic                           wr_valid;
    logic                           wr_ready;
    logic [ADDR_BITS-1:0]           wr_addr;
    logic [DATA_BITS-1:0]           wr_data;
    logic [NUM_REQ-1:0]             rd_valid;
    logic [NUM_REQ-1:0]             rd_ready;
    logic [NUM_REQ*ADDR_BITS-1:0]   rd_addr;
    logic                           rsp_valid;
    logic [ID_BITS-1:0]             rsp_id;
    logic [DATA_BITS-1:0]           rsp_data;
    logic                           ram_en;
    logic                           ram_we;
    logic [ADDR_BITS-1:0]           ram_addr;
    logic [DATA_BITS-1:0]           ram_wdata;
    logic [DATA_BITS-1:0]           ram_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
        output wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
        input  wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/weights_ram_arbiter.sv
// Single-port weights RAM arbiter: loader writes win, bounded by a starvation limit;
// lane reads are round-robin and responses come back one cycle later tagged with the lane id.
module weights_ram_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_BITS       = 3,
    parameter int DATA_BITS       = 8,
    parameter int WR_STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    weights_ram_arbiter_if.slave  bus
);
    localparam int ID_BITS  = $clog2(NUM_REQ);
    localparam int STK_BITS = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [STK_BITS-1:0] STK_MAX = STK_BITS'(WR_STARVE_LIMIT);

    logic [ID_BITS-1:0]   r_rr_ptr;
    logic [ID_BITS-1:0]   r_rsp_id;
    logic [STK_BITS-1:0]  r_streak;
    logic                 r_rsp_valid;

    logic                 w_rd_any;
    logic                 w_rd_found;
    logic [ID_BITS-1:0]   w_lane;
    logic [ID_BITS-1:0]   w_rd_idx;
    logic [ID_BITS-1:0]   w_rr_next;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic [NUM_REQ-1:0]   w_rd_onehot;
    logic                 w_starve;
    logic                 w_wr_gnt;
    logic                 w_rd_gnt;

    assign w_rd_any = |bus.rd_valid;

    // First valid lane at or after rr_ptr, wrapping.
    always_comb begin
        w_rd_found = 1'b0;
        w_rd_idx   = '0;
        w_lane     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_lane = ID_BITS'((int'(r_rr_ptr) + off) % NUM_REQ);
            if (!w_rd_found && bus.rd_valid[w_lane]) begin
                w_rd_found = 1'b1;
                w_rd_idx   = w_lane;
            end
        end
    end

    assign w_starve = (r_streak == STK_MAX) && w_rd_any;
    assign w_wr_gnt = !rst && bus.wr_valid && !w_starve;
    assign w_rd_gnt = !rst && w_rd_found && !w_wr_gnt;

    always_comb begin
        w_rd_addr   = '0;
        w_rd_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rd_idx == ID_BITS'(i)) begin
                w_rd_addr      = bus.rd_addr[i*ADDR_BITS +: ADDR_BITS];
                w_rd_onehot[i] = 1'b1;
            end
        end
    end

    assign w_rr_next = (w_rd_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : w_rd_idx + 1'b1;

    assign bus.wr_ready = w_wr_gnt;
    assign bus.rd_ready = w_rd_gnt ? w_rd_onehot : '0;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (w_wr_gnt) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = bus.wr_addr;
            bus.ram_wdata = bus.wr_data;
        end else if (w_rd_gnt) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = w_rd_addr;
        end
    end

    // A response still in flight when reset hits is dropped, not delayed.
    assign bus.rsp_valid = r_rsp_valid && !rst;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_streak    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rsp_id <= w_rd_idx;
                r_rr_ptr <= w_rr_next;
            end
            if (w_rd_gnt || !w_rd_any)
                r_streak <= '0;
            else if (w_wr_gnt && r_streak != STK_MAX)
                r_streak <= r_streak + 1'b1;
        end
    end
endmodule
